// File: rtl/ps2_kb_pkg.sv
// ps2_kb_pkg: shared constants and state encoding for the PS/2 key-set decoder.
package ps2_kb_pkg;

    // Protocol bytes from the keyboard
    localparam logic [7:0] PS2_EXT = 8'hE0;   // extended-code prefix
    localparam logic [7:0] PS2_BRK = 8'hF0;   // break (key up) prefix
    localparam logic [7:0] PS2_BAT = 8'hAA;   // basic assurance test passed (keyboard reset)

    // Decoder FSM encoding
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        EXT     = 2'd1,
        BRK     = 2'd2,
        EXT_BRK = 2'd3
    } kb_state_e;

    // Default six-key set: key0=1C, key1=23, key2=1D, key3=1B, key4=2D, key5=29
    localparam int           KB_DEF_NUM_KEYS = 6;
    localparam logic [47:0]  KB_DEF_CODES    = {8'h29, 8'h2D, 8'h1B, 8'h1D, 8'h23, 8'h1C};
    localparam logic [5:0]   KB_DEF_EXT      = 6'b000000;

    // Index width able to address n keys (at least one bit)
    function automatic int kb_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/kb_repeat_timer.sv
// kb_repeat_timer: delay-then-period tick generator for key auto-repeat.
// Only instantiated when PS2_KEYSET_AUTO_REPEAT_EN is defined.
// start arms a down-counter with DELAY-1; each terminal count raises tick for
// one cycle and reloads PERIOD-1. stop has priority over start.
module kb_repeat_timer #(
    parameter int DELAY  = 50_000_000,
    parameter int PERIOD = 10_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic stop,
    output logic tick
);

    localparam logic [31:0] DELAY_LD  = 32'(DELAY - 1);
    localparam logic [31:0] PERIOD_LD = 32'(PERIOD - 1);

    logic        active_q, active_d;
    logic [31:0] cnt_q, cnt_d;

    // Next counter value: arm, disarm, or count down and reload on terminal count
    always_comb begin
        active_d = active_q;
        cnt_d    = cnt_q;
        tick     = active_q && (cnt_q == 32'd0);
        if (stop) begin
            active_d = 1'b0;
            cnt_d    = 32'd0;
        end else if (start) begin
            active_d = 1'b1;
            cnt_d    = DELAY_LD;
        end else if (active_q) begin
            if (cnt_q == 32'd0) begin
                cnt_d = PERIOD_LD;
            end else begin
                cnt_d = cnt_q - 32'd1;
            end
        end
    end

    // Counter registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            active_q <= 1'b0;
            cnt_q    <= 32'd0;
        end else begin
            active_q <= active_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: rtl/ps2_keyset_decoder.sv
// ps2_keyset_decoder: decodes an N-key set from the ps2_rx byte stream into
// held levels plus single-cycle press/release pulses.
// Optional feature macro: PS2_KEYSET_AUTO_REPEAT_EN (auto-repeat of the most
// recently pressed key via kb_repeat_timer).
//
// state   | meaning
// --------+------------------------------------------------
// IDLE    | waiting for a byte; plain codes are makes
// EXT     | E0 seen; next non-prefix byte is an extended make
// BRK     | F0 seen; next byte is a plain break
// EXT_BRK | E0,F0 seen; next byte is an extended break
module ps2_keyset_decoder
    import ps2_kb_pkg::*;
#(
    parameter int                      NUM_KEYS      = KB_DEF_NUM_KEYS,
    parameter logic [NUM_KEYS*8-1:0]   KEY_CODES     = KB_DEF_CODES,
    parameter logic [NUM_KEYS-1:0]     KEY_EXT       = KB_DEF_EXT,
    parameter int                      TIMEOUT_CYC   = 2_000_000,
    parameter int                      REPEAT_DELAY  = 50_000_000,
    parameter int                      REPEAT_PERIOD = 10_000_000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                rx_done_tick,
    input  logic [7:0]          scan_code,
    input  logic                flush,
    output logic [NUM_KEYS-1:0] key_held,
    output logic [NUM_KEYS-1:0] key_press,
    output logic [NUM_KEYS-1:0] key_release,
    output logic                busy
);

    localparam logic [31:0] TMO_LAST = 32'(TIMEOUT_CYC - 1);

    kb_state_e           state_q, state_d;
    logic [NUM_KEYS-1:0] held_q, held_d;
    logic [NUM_KEYS-1:0] press_q, press_d;
    logic [NUM_KEYS-1:0] release_q, release_d;
    logic                busy_q, busy_d;
    logic [31:0]         tmo_q, tmo_d;

    logic [NUM_KEYS-1:0] match_std;
    logic [NUM_KEYS-1:0] match_ext;
    logic [NUM_KEYS-1:0] match_sel;
    logic                ev_make;
    logic                ev_brk;
    logic                ev_ext;
    logic                bat_clr;

`ifdef PS2_KEYSET_AUTO_REPEAT_EN
    localparam int IDX_W = kb_idx_w(NUM_KEYS);

    logic [IDX_W-1:0] trk_q, trk_d;
    logic             rpt_start;
    logic             rpt_stop;
    logic             rpt_tick;

    kb_repeat_timer #(
        .DELAY  (REPEAT_DELAY),
        .PERIOD (REPEAT_PERIOD)
    ) u_repeat (
        .clk   (clk),
        .reset (reset),
        .start (rpt_start),
        .stop  (rpt_stop),
        .tick  (rpt_tick)
    );
`endif

    // Per-key code compare, split by whether the key needs the E0 prefix
    always_comb begin
        match_std = '0;
        match_ext = '0;
        for (int i = 0; i < NUM_KEYS; i++) begin
            match_std[i] = (scan_code == KEY_CODES[8*i +: 8]) && !KEY_EXT[i];
            match_ext[i] = (scan_code == KEY_CODES[8*i +: 8]) &&  KEY_EXT[i];
        end
    end

    // Next state, prefix timeout, and key make/break effects
    always_comb begin
        state_d   = state_q;
        held_d    = held_q;
        press_d   = '0;
        release_d = '0;
        tmo_d     = tmo_q;
        ev_make   = 1'b0;
        ev_brk    = 1'b0;
        ev_ext    = 1'b0;
        bat_clr   = 1'b0;

        if (flush) begin
            // flush wins over a coincident byte, which is dropped
            state_d = IDLE;
            held_d  = '0;
            tmo_d   = 32'd0;
        end else if (rx_done_tick) begin
            tmo_d = 32'd0;
            unique case (state_q)
                IDLE: begin
                    if (scan_code == PS2_EXT) begin
                        state_d = EXT;
                    end else if (scan_code == PS2_BRK) begin
                        state_d = BRK;
                    end else if (scan_code == PS2_BAT) begin
                        bat_clr = 1'b1;
                        held_d  = '0;
                    end else begin
                        ev_make = 1'b1;
                    end
                end
                EXT: begin
                    if (scan_code == PS2_BRK) begin
                        state_d = EXT_BRK;
                    end else if (scan_code == PS2_EXT) begin
                        state_d = EXT;
                    end else begin
                        ev_make = 1'b1;
                        ev_ext  = 1'b1;
                        state_d = IDLE;
                    end
                end
                BRK: begin
                    ev_brk  = 1'b1;
                    state_d = IDLE;
                end
                EXT_BRK: begin
                    ev_brk  = 1'b1;
                    ev_ext  = 1'b1;
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end else if (state_q != IDLE) begin
            // A stalled prefix is abandoned without producing an event
            if (tmo_q == TMO_LAST) begin
                state_d = IDLE;
                tmo_d   = 32'd0;
            end else begin
                tmo_d = tmo_q + 32'd1;
            end
        end

        match_sel = ev_ext ? match_ext : match_std;

        // Typematic repeats of an already-held key produce no pulse
        if (ev_make) begin
            press_d = match_sel & ~held_q;
            held_d  = held_q | match_sel;
        end
        if (ev_brk) begin
            release_d = match_sel & held_q;
            held_d    = held_q & ~match_sel;
        end

`ifdef PS2_KEYSET_AUTO_REPEAT_EN
        trk_d     = trk_q;
        rpt_start = |press_d;
        rpt_stop  = flush || bat_clr;
        // Lowest-numbered fresh press becomes the tracked key
        for (int i = NUM_KEYS - 1; i >= 0; i--) begin
            if (press_d[i]) begin
                trk_d = IDX_W'(i);
            end
        end
        for (int i = 0; i < NUM_KEYS; i++) begin
            if ((trk_q == IDX_W'(i)) && release_d[i]) begin
                rpt_stop = 1'b1;
            end
        end
        if (rpt_tick && !rpt_start && !rpt_stop) begin
            for (int i = 0; i < NUM_KEYS; i++) begin
                if ((trk_q == IDX_W'(i)) && held_q[i]) begin
                    press_d[i] = 1'b1;
                end
            end
        end
`endif

        busy_d = (state_d != IDLE);
    end

    // State and registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            held_q    <= '0;
            press_q   <= '0;
            release_q <= '0;
            busy_q    <= 1'b0;
            tmo_q     <= 32'd0;
`ifdef PS2_KEYSET_AUTO_REPEAT_EN
            trk_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            held_q    <= held_d;
            press_q   <= press_d;
            release_q <= release_d;
            busy_q    <= busy_d;
            tmo_q     <= tmo_d;
`ifdef PS2_KEYSET_AUTO_REPEAT_EN
            trk_q     <= trk_d;
`endif
        end
    end

    assign key_held    = held_q;
    assign key_press   = press_q;
    assign key_release = release_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_ps2_keyset_decoder.sv
// tb_ps2_keyset_decoder: directed, table-driven bench for ps2_keyset_decoder.
// Default key set, key2 (code 1D) configured as extended, short prefix timeout.
module tb_ps2_keyset_decoder;

    localparam int NK  = 6;
    localparam int TMO = 40;

    logic          clk;
    logic          reset;
    logic          rx_done_tick;
    logic [7:0]    scan_code;
    logic          flush;
    logic [NK-1:0] key_held;
    logic [NK-1:0] key_press;
    logic [NK-1:0] key_release;
    logic          busy;

    int n_checks;
    int n_err;

    ps2_keyset_decoder #(
        .NUM_KEYS      (NK),
        .KEY_CODES     ({8'h29, 8'h2D, 8'h1B, 8'h1D, 8'h23, 8'h1C}),
        .KEY_EXT       (6'b000100),
        .TIMEOUT_CYC   (TMO),
        .REPEAT_DELAY  (100),
        .REPEAT_PERIOD (20)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .rx_done_tick (rx_done_tick),
        .scan_code    (scan_code),
        .flush        (flush),
        .key_held     (key_held),
        .key_press    (key_press),
        .key_release  (key_release),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic          rx;
        logic [7:0]    code;
        logic          fl;
        logic [NK-1:0] held;
        logic [NK-1:0] press;
        logic [NK-1:0] rel;
        logic          bsy;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic rx, input logic [7:0] code, input logic fl,
                                input logic [NK-1:0] held, input logic [NK-1:0] press,
                                input logic [NK-1:0] rel, input logic bsy);
        vec_t v;
        v.rx = rx; v.code = code; v.fl = fl;
        v.held = held; v.press = press; v.rel = rel; v.bsy = bsy;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One clock: drive on the falling edge, sample 1 time unit after the rising edge
    task automatic step(input logic rx, input logic [7:0] code, input logic fl);
        @(negedge clk);
        rx_done_tick = rx;
        scan_code    = code;
        flush        = fl;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int hits[$];
        int cnt;

        n_checks     = 0;
        n_err        = 0;
        reset        = 1'b0;
        rx_done_tick = 1'b0;
        scan_code    = 8'h00;
        flush        = 1'b0;

        //            rx  code   fl  held      press     rel       busy
        vecs.push_back(mk(1, 8'h1C, 0, 6'h01, 6'h01, 6'h00, 0));
        vecs.push_back(mk(0, 8'h00, 0, 6'h01, 6'h00, 6'h00, 0));
        vecs.push_back(mk(1, 8'hF0, 0, 6'h01, 6'h00, 6'h00, 1));
        vecs.push_back(mk(1, 8'h1C, 0, 6'h00, 6'h00, 6'h01, 0));
        vecs.push_back(mk(1, 8'h23, 0, 6'h02, 6'h02, 6'h00, 0));
        vecs.push_back(mk(1, 8'h23, 0, 6'h02, 6'h00, 6'h00, 0));
        vecs.push_back(mk(1, 8'h23, 0, 6'h02, 6'h00, 6'h00, 0));
        vecs.push_back(mk(1, 8'h1D, 0, 6'h02, 6'h00, 6'h00, 0));
        vecs.push_back(mk(1, 8'hE0, 0, 6'h02, 6'h00, 6'h00, 1));
        vecs.push_back(mk(1, 8'h1D, 0, 6'h06, 6'h04, 6'h00, 0));
        vecs.push_back(mk(1, 8'hE0, 0, 6'h06, 6'h00, 6'h00, 1));
        vecs.push_back(mk(1, 8'hF0, 0, 6'h06, 6'h00, 6'h00, 1));
        vecs.push_back(mk(1, 8'h1D, 0, 6'h02, 6'h00, 6'h04, 0));
        vecs.push_back(mk(1, 8'h1C, 0, 6'h03, 6'h01, 6'h00, 0));
        vecs.push_back(mk(1, 8'hAA, 0, 6'h00, 6'h00, 6'h00, 0));
        vecs.push_back(mk(1, 8'h1C, 0, 6'h01, 6'h01, 6'h00, 0));
        vecs.push_back(mk(1, 8'h23, 0, 6'h03, 6'h02, 6'h00, 0));
        vecs.push_back(mk(0, 8'h00, 1, 6'h00, 6'h00, 6'h00, 0));
        vecs.push_back(mk(1, 8'h2D, 1, 6'h00, 6'h00, 6'h00, 0));
        vecs.push_back(mk(1, 8'hE0, 0, 6'h00, 6'h00, 6'h00, 1));
        vecs.push_back(mk(0, 8'h00, 1, 6'h00, 6'h00, 6'h00, 0));
        vecs.push_back(mk(1, 8'h2D, 0, 6'h10, 6'h10, 6'h00, 0));
        vecs.push_back(mk(1, 8'hF0, 0, 6'h10, 6'h00, 6'h00, 1));
        vecs.push_back(mk(1, 8'h2D, 0, 6'h00, 6'h00, 6'h10, 0));
        vecs.push_back(mk(1, 8'h55, 0, 6'h00, 6'h00, 6'h00, 0));
        vecs.push_back(mk(1, 8'hE0, 0, 6'h00, 6'h00, 6'h00, 1));
        vecs.push_back(mk(1, 8'h1C, 0, 6'h00, 6'h00, 6'h00, 0));
        vecs.push_back(mk(1, 8'hE0, 0, 6'h00, 6'h00, 6'h00, 1));
        vecs.push_back(mk(1, 8'hE0, 0, 6'h00, 6'h00, 6'h00, 1));
        vecs.push_back(mk(1, 8'h1D, 0, 6'h04, 6'h04, 6'h00, 0));
        vecs.push_back(mk(1, 8'hE0, 0, 6'h04, 6'h00, 6'h00, 1));
        vecs.push_back(mk(1, 8'hF0, 0, 6'h04, 6'h00, 6'h00, 1));
        vecs.push_back(mk(1, 8'h1D, 0, 6'h00, 6'h00, 6'h04, 0));
        vecs.push_back(mk(1, 8'hF0, 0, 6'h00, 6'h00, 6'h00, 1));
        vecs.push_back(mk(1, 8'hF0, 0, 6'h00, 6'h00, 6'h00, 0));

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("reset held",    32'(key_held),    32'h0);
        check("reset press",   32'(key_press),   32'h0);
        check("reset release", 32'(key_release), 32'h0);
        check("reset busy",    32'(busy),        32'h0);
        @(negedge clk);
        reset = 1'b1;

        // Table-driven vectors
        foreach (vecs[i]) begin
            step(vecs[i].rx, vecs[i].code, vecs[i].fl);
            check($sformatf("v%0d held", i),    32'(key_held),    32'(vecs[i].held));
            check($sformatf("v%0d press", i),   32'(key_press),   32'(vecs[i].press));
            check($sformatf("v%0d release", i), 32'(key_release), 32'(vecs[i].rel));
            check($sformatf("v%0d busy", i),    32'(busy),        32'(vecs[i].bsy));
            check($sformatf("v%0d overlap", i), 32'(key_press & key_release), 32'h0);
        end

        // Prefix timeout: F0 then silence; busy drops after exactly TMO cycles
        step(1'b1, 8'hF0, 1'b0);
        check("tmo busy start", 32'(busy), 32'h1);
        for (int m = 1; m <= TMO; m++) begin
            step(1'b0, 8'h00, 1'b0);
            if (m == TMO - 1) check("tmo busy before", 32'(busy), 32'h1);
            if (m == TMO)     check("tmo busy after",  32'(busy), 32'h0);
        end
        step(1'b1, 8'h1B, 1'b0);
        check("tmo make press", 32'(key_press), 32'h08);
        check("tmo make held",  32'(key_held),  32'h08);
        step(1'b1, 8'hF0, 1'b0);
        step(1'b1, 8'h1B, 1'b0);
        check("tmo brk release", 32'(key_release), 32'h08);
        check("tmo brk held",    32'(key_held),    32'h00);

        // Asynchronous reset in the middle of an extended sequence
        step(1'b1, 8'h1C, 1'b0);
        step(1'b1, 8'hE0, 1'b0);
        check("pre-rst busy", 32'(busy),     32'h1);
        check("pre-rst held", 32'(key_held), 32'h01);
        @(negedge clk);
        rx_done_tick = 1'b0;
        reset        = 1'b0;
        #1;
        check("async rst held",    32'(key_held),    32'h0);
        check("async rst busy",    32'(busy),        32'h0);
        check("async rst press",   32'(key_press),   32'h0);
        check("async rst release", 32'(key_release), 32'h0);
        @(negedge clk);
        reset = 1'b1;
        step(1'b1, 8'h1C, 1'b0);
        check("post-rst press", 32'(key_press), 32'h01);
        check("post-rst held",  32'(key_held),  32'h01);
        check("post-rst busy",  32'(busy),      32'h0);
        step(1'b1, 8'hAA, 1'b0);
        check("post-rst bat held", 32'(key_held), 32'h00);

`ifdef PS2_KEYSET_AUTO_REPEAT_EN
        // Auto-repeat of key5: pulses at +1, +101, +121, +141
        step(1'b1, 8'h29, 1'b0);
        if (key_press[5]) hits.push_back(1);
        for (int j = 2; j <= 150; j++) begin
            step(1'b0, 8'h00, 1'b0);
            if (key_press[5]) hits.push_back(j);
        end
        check("rpt count", 32'(hits.size()), 32'd4);
        if (hits.size() == 4) begin
            check("rpt hit0", 32'(hits[0]), 32'd1);
            check("rpt hit1", 32'(hits[1]), 32'd101);
            check("rpt hit2", 32'(hits[2]), 32'd121);
            check("rpt hit3", 32'(hits[3]), 32'd141);
        end
        step(1'b1, 8'hF0, 1'b0);
        step(1'b1, 8'h29, 1'b0);
        check("rpt brk release", 32'(key_release), 32'h20);
        cnt = 0;
        for (int j = 0; j < 60; j++) begin
            step(1'b0, 8'h00, 1'b0);
            if (key_press != '0) cnt++;
        end
        check("rpt stopped", 32'(cnt), 32'd0);
`endif

        step(1'b0, 8'h00, 1'b0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/ps2_keyset_decoder.md
Name: ps2_keyset_decoder

Overview:
- Parametrised successor to the per-key kb_controller + blipgen pair. One instance decodes an N-key set from the ps2_rx byte stream.
- Tracks make, break and E0-extended codes for every key, and keeps a held level per key.
- Emits single-cycle press and release pulses, so no per-key blip modules are needed.
- Sits between ps2_rx and the game/display engine.

Parameters:
- NUM_KEYS, 6, number of decoded keys (1..32).
- KEY_CODES, {8'h29,8'h2D,8'h1B,8'h1D,8'h23,8'h1C}, packed NUM_KEYS*8 scan codes; key i uses bits [8i+7:8i] (default key0=1C, 1=23, 2=1D, 3=1B, 4=2D, 5=29).
- KEY_EXT, 6'b000000, per-key flag: 1 means the key requires the E0 prefix.
- TIMEOUT_CYC, 2_000_000, clock cycles allowed in a prefix state before abandoning it (20 ms at 100 MHz).
- REPEAT_DELAY, 50_000_000, cycles from press to first auto-repeat (used only with the macro).
- REPEAT_PERIOD, 10_000_000, cycles between subsequent auto-repeats (used only with the macro).

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- rx_done_tick  in  1  one-cycle strobe from ps2_rx marking a valid byte
- scan_code  in  8  byte from ps2_rx, valid while rx_done_tick=1
- flush  in  1  synchronous clear of all held keys
- key_held  out  NUM_KEYS  level: key currently down
- key_press  out  NUM_KEYS  one-cycle pulse on make (and on auto-repeat, if enabled)
- key_release  out  NUM_KEYS  one-cycle pulse on break
- busy  out  1  decoder is in a prefix state (not IDLE)

Behaviour:
- Reset (reset=0, asynchronous): all outputs 0, FSM in IDLE, timeout and repeat counters 0.
- The FSM advances only on rx_done_tick=1.
  - IDLE: E0 → EXT; F0 → BRK; AA (BAT) → clear all held with no release pulses, stay IDLE; any other byte → non-extended make, stay IDLE.
  - EXT: F0 → EXT_BRK; E0 → EXT; other → extended make, go to IDLE.
  - BRK: any byte → non-extended break, go to IDLE.
  - EXT_BRK: any byte → extended break, go to IDLE.
- Matching: key i matches when scan_code == KEY_CODES[i] and the event's extended flag == KEY_EXT[i]. All matching keys act in parallel; duplicate codes are legal.
- Make on a matching key:
  - If key_held[i]=0: key_held[i] becomes 1 and key_press[i] pulses, both in the cycle after rx_done_tick (latency 1).
  - If already held (keyboard typematic repeat): no pulse.
- Break on a matching key:
  - If held: key_held[i] becomes 0 and key_release[i] pulses, latency 1.
  - If not held: ignored.
- Unmatched codes are discarded with no output change.
- Timeout: the counter clears on every rx_done_tick and counts only while busy=1. On reaching TIMEOUT_CYC-1 the FSM returns to IDLE with no event.
- flush=1 clears all key_held and returns the FSM to IDLE next cycle, with no release pulses. If flush coincides with rx_done_tick, flush wins and the byte is dropped.
- key_press and key_release are never both 1 for the same key in the same cycle.
- busy = (state != IDLE), registered.

Optional Feature:
- Macro: PS2_KEYSET_AUTO_REPEAT_EN.
- Defined:
  - One shared repeat timer tracks the most recently pressed key (the last make that produced a pulse).
  - After REPEAT_DELAY cycles of that key held, key_press for it pulses again, then every REPEAT_PERIOD cycles.
  - Break of the tracked key, flush, BAT, or reset stops repeats.
  - Pressing another key retargets the timer and restarts it from zero.
- Undefined: no timer logic; key_press pulses only on a fresh make; the REPEAT_* parameters are unused.

Decomposition:
- Package ps2_kb_pkg:
  - constants PS2_EXT=8'hE0, PS2_BRK=8'hF0, PS2_BAT=8'hAA
  - FSM state encoding {IDLE, EXT, BRK, EXT_BRK}
  - default key-code constants
- Sub-module kb_repeat_timer: delay/period counter with start, stop and a tick output. Instantiated only under the macro.

Test Plan:
- Send 1C → key_held[0]=1 and key_press[0] pulses exactly 1 cycle after the strobe. Then F0,1C → key_release[0] pulses and key_held[0]=0.
- Hold 23: send 23,23,23 (typematic) → exactly one key_press[1] pulse, key_held[1] stays 1.
- With KEY_EXT[2]=1, send 1D → no response. Then E0,1D → key_press[2]. Then E0,F0,1D → key_release[2].
- Send F0, then nothing for TIMEOUT_CYC cycles → busy falls to 0. Then 1B → treated as a make, so key_press[3] pulses.
- Hold 1C and 23, then send AA or assert flush → key_held=0 with no release pulses. flush together with a 2D strobe → no key_press[4].
- Macro defined, REPEAT_DELAY=100, REPEAT_PERIOD=20, hold 29 → key_press[5] at +1, +101, +121, +141 cycles. F0,29 → repeats stop.
- Reset low mid-sequence (after E0) → all outputs 0 immediately. After release of reset, 1C decodes as non-extended.
